axi_stream_insert_arb: RTL and testbench

Packet-level round-robin arbiter that shares one axi_stream_insert core between N_CH requesters. Each requester has its own payload stream and header (insert) channel. The arbiter grants one channel for a whole packet and muxes that channel's payload and header signals into the core. It holds the grant until the core completes the header handshake, which the core performs on the final output beat. It also exports the owning channel id so downstream logic can tag output beats.

---
 rtl/axi_stream_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/axi_stream_insert_arb.sv | 134 +++++++++++++
 tb/tb_axi_stream_insert_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-stream insert arbiter slice.
// Default widths, FSM state encoding and bus slice helpers.
package axi_stream_pkg;

    localparam int DATA_WD_DEF      = 32;
    localparam int DATA_BYTE_WD_DEF = DATA_WD_DEF >> 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY
    } arb_state_e;

    // Low bit of slice idx in a flattened bus of w-bit lanes.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: rotate by ptr, take lowest set
// bit, unrotate back to an absolute index. Works for any N >= 2.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [PW-1:0] sel,
    output logic          any
);

    logic [N-1:0] rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    assign rot = N'({req, req} >> ptr);
    assign any = |req;

    // Lowest set bit of the rotated request wins.
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign sel = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                     : sum[PW-1:0];

endmodule

// File: rtl/axi_stream_insert_arb.sv
// Packet-level round-robin arbiter sharing one insert core among
// N_CH requesters; grant held until the core's header handshake.
module axi_stream_insert_arb
    import axi_stream_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DATA_WD      = DATA_WD_DEF,
    parameter int DATA_BYTE_WD = DATA_WD >> 3,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int CH_WD        = $clog2(N_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH-1:0]              ch_en,
    input  logic [N_CH-1:0]              s_valid_in,
    input  logic [N_CH-1:0]              s_last_in,
    input  logic [N_CH*DATA_WD-1:0]      s_data_in,
    input  logic [N_CH*DATA_BYTE_WD-1:0] s_keep_in,
    output logic [N_CH-1:0]              s_ready_in,
    input  logic [N_CH-1:0]              s_valid_insert,
    input  logic [N_CH*DATA_WD-1:0]      s_data_insert,
    input  logic [N_CH*DATA_BYTE_WD-1:0] s_keep_insert,
    input  logic [N_CH*BYTE_CNT_WD-1:0]  s_byte_insert_cnt,
    output logic [N_CH-1:0]              s_ready_insert,
    output logic                         core_valid_in,
    output logic                         core_last_in,
    output logic [DATA_WD-1:0]           core_data_in,
    output logic [DATA_BYTE_WD-1:0]      core_keep_in,
    input  logic                         core_ready_in,
    output logic                         core_valid_insert,
    output logic [DATA_WD-1:0]           core_data_insert,
    output logic [DATA_BYTE_WD-1:0]      core_keep_insert,
    output logic [BYTE_CNT_WD-1:0]       core_byte_insert_cnt,
    input  logic                         core_ready_insert,
    output logic                         grant_valid,
    output logic [CH_WD-1:0]             grant_id,
    output logic                         pkt_done
);

    arb_state_e state_q, state_d;
    logic [CH_WD-1:0] rr_ptr;
    logic [CH_WD-1:0] sel_id;
    logic [N_CH-1:0]  req;
    logic             req_any;
    logic             busy;
    logic             hdr_hs;

    logic [DATA_WD-1:0]      din_a  [N_CH];
    logic [DATA_BYTE_WD-1:0] kin_a  [N_CH];
    logic [DATA_WD-1:0]      dins_a [N_CH];
    logic [DATA_BYTE_WD-1:0] kins_a [N_CH];
    logic [BYTE_CNT_WD-1:0]  cnt_a  [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign din_a[i]  = s_data_in[slice_lo(i, DATA_WD) +: DATA_WD];
        assign kin_a[i]  = s_keep_in[slice_lo(i, DATA_BYTE_WD) +: DATA_BYTE_WD];
        assign dins_a[i] = s_data_insert[slice_lo(i, DATA_WD) +: DATA_WD];
        assign kins_a[i] = s_keep_insert[slice_lo(i, DATA_BYTE_WD) +: DATA_BYTE_WD];
        assign cnt_a[i]  = s_byte_insert_cnt[slice_lo(i, BYTE_CNT_WD) +: BYTE_CNT_WD];
    end

    assign req  = ch_en & s_valid_in & s_valid_insert;
    assign busy = (state_q == BUSY);

    rr_arbiter #(
        .N  (N_CH),
        .PW (CH_WD)
    ) u_rr (
        .ptr (rr_ptr),
        .req (req),
        .sel (sel_id),
        .any (req_any)
    );

    assign core_valid_in        = busy & s_valid_in[grant_id];
    assign core_last_in         = s_last_in[grant_id];
    assign core_data_in         = din_a[grant_id];
    assign core_keep_in         = kin_a[grant_id];
    assign core_valid_insert    = busy & s_valid_insert[grant_id];
    assign core_data_insert     = dins_a[grant_id];
    assign core_keep_insert     = kins_a[grant_id];
    assign core_byte_insert_cnt = cnt_a[grant_id];

    assign hdr_hs = core_valid_insert & core_ready_insert;

    // Route core readies back to the owning channel only.
    always_comb begin
        s_ready_in     = '0;
        s_ready_insert = '0;
        if (busy) begin
            s_ready_in[grant_id]     = core_ready_in;
            s_ready_insert[grant_id] = core_ready_insert;
        end
    end

    // Next state: grant on any request, release on header handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_any) state_d = BUSY;
            BUSY:    if (hdr_hs)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant bookkeeping, done pulse and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id    <= '0;
            grant_valid <= 1'b0;
            pkt_done    <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            pkt_done <= 1'b0;
            if (!busy && req_any) begin
                grant_id    <= sel_id;
                grant_valid <= 1'b1;
            end
            if (busy && hdr_hs) begin
                grant_valid <= 1'b0;
                pkt_done    <= 1'b1;
                rr_ptr      <= (grant_id == CH_WD'(N_CH - 1))
                             ? '0 : grant_id + CH_WD'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_arb.sv
// Randomized bench for axi_stream_insert_arb with a packet-level
// round-robin reference model and a simple core stand-in.
module tb_axi_stream_insert_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    ch_en, s_valid_in, s_last_in, s_ready_in;
    logic [N*DW-1:0] s_data_in, s_data_insert;
    logic [N*BW-1:0] s_keep_in, s_keep_insert;
    logic [N*CW-1:0] s_byte_insert_cnt;
    logic [N-1:0]    s_valid_insert, s_ready_insert;
    logic            core_valid_in, core_last_in, core_ready_in;
    logic [DW-1:0]   core_data_in, core_data_insert;
    logic [BW-1:0]   core_keep_in, core_keep_insert;
    logic [CW-1:0]   core_byte_insert_cnt;
    logic            core_valid_insert, core_ready_insert;
    logic            grant_valid, pkt_done;
    logic [GW-1:0]   grant_id;

    axi_stream_insert_arb #(.N_CH(N), .DATA_WD(DW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ch_en                (ch_en),
        .s_valid_in           (s_valid_in),
        .s_last_in            (s_last_in),
        .s_data_in            (s_data_in),
        .s_keep_in            (s_keep_in),
        .s_ready_in           (s_ready_in),
        .s_valid_insert       (s_valid_insert),
        .s_data_insert        (s_data_insert),
        .s_keep_insert        (s_keep_insert),
        .s_byte_insert_cnt    (s_byte_insert_cnt),
        .s_ready_insert       (s_ready_insert),
        .core_valid_in        (core_valid_in),
        .core_last_in         (core_last_in),
        .core_data_in         (core_data_in),
        .core_keep_in         (core_keep_in),
        .core_ready_in        (core_ready_in),
        .core_valid_insert    (core_valid_insert),
        .core_data_insert     (core_data_insert),
        .core_keep_insert     (core_keep_insert),
        .core_byte_insert_cnt (core_byte_insert_cnt),
        .core_ready_insert    (core_ready_insert),
        .grant_valid          (grant_valid),
        .grant_id             (grant_id),
        .pkt_done             (pkt_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Requester-side packet state.
    logic [N-1:0]  vin, hv, en, pf;
    logic [DW-1:0] cdata[N], hdata[N];
    logic [BW-1:0] ckeep[N], hkeep[N], lkeep[N];
    logic [CW-1:0] hcnt[N];
    int            len[N], beat[N];
    bit            has[N];
    logic          rdy;
    logic [BW-1:0] ktab[4] = '{4'h8, 4'hC, 4'hE, 4'hF};

    // Stimulus knobs.
    int pv, ph, pr, flen;
    logic [N-1:0] en_mask;
    bit rand_en, rec;
    int gq[$];

    // Reference model state.
    bit m_busy, m_done;
    int m_gid, m_ptr;

    always_comb begin
        s_data_in = '0; s_keep_in = '0; s_last_in = '0;
        s_data_insert = '0; s_keep_insert = '0; s_byte_insert_cnt = '0;
        for (int i = 0; i < N; i++) begin
            s_data_in[i*DW +: DW]         = cdata[i];
            s_keep_in[i*BW +: BW]         = ckeep[i];
            s_last_in[i]                  = (beat[i] == len[i] - 1);
            s_data_insert[i*DW +: DW]     = hdata[i];
            s_keep_insert[i*BW +: BW]     = hkeep[i];
            s_byte_insert_cnt[i*CW +: CW] = hcnt[i];
        end
    end

    assign s_valid_in        = vin;
    assign s_valid_insert    = hv;
    assign ch_en             = en;
    assign core_ready_in     = rdy;
    assign core_ready_insert = core_valid_in & core_last_in & core_ready_in;

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic gen(input int i);
        len[i]   = (flen > 0) ? flen : int'($urandom_range(1, 4));
        beat[i]  = 0;
        cdata[i] = $urandom;
        hdata[i] = $urandom;
        hkeep[i] = BW'($urandom);
        hcnt[i]  = (flen > 0) ? CW'(2) : CW'($urandom);
        lkeep[i] = ktab[$urandom_range(0, 3)];
        ckeep[i] = (len[i] == 1) ? lkeep[i] : 4'hF;
        has[i]   = 1'b1;
        hv[i]    = 1'b0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!has[i]) gen(i);
            if (!hv[i] && $urandom_range(0, 99) < ph) hv[i] = 1'b1;
            vin[i] = ($urandom_range(0, 99) < pv);
        end
        if (rand_en && $urandom_range(0, 19) == 0) en_mask = N'($urandom);
        en  = en_mask;
        rdy = ($urandom_range(0, 99) < pr);
    endtask

    task automatic step();
        int g, p, nptr, ngid;
        bit nb, nd;
        logic rel;
        logic [N-1:0] req;
        @(negedge clk);
        g = m_gid;
        chk("grant", {grant_valid, grant_id, pkt_done},
            {m_busy, GW'(m_gid), m_done});
        rel = 1'b0;
        if (m_busy) begin
            rel = hv[g] & vin[g] & rdy & (beat[g] == len[g] - 1);
            chk("core_in",
                {core_valid_in, core_last_in, core_data_in, core_keep_in},
                {vin[g], beat[g] == len[g] - 1, cdata[g], ckeep[g]});
            chk("core_ins",
                {core_valid_insert, core_data_insert, core_keep_insert,
                 core_byte_insert_cnt},
                {hv[g], hdata[g], hkeep[g], hcnt[g]});
            chk("ready", {s_ready_in, s_ready_insert},
                {rdy ? N'(1 << g) : N'(0), rel ? N'(1 << g) : N'(0)});
        end else begin
            chk("idle", {core_valid_in, core_valid_insert,
                         s_ready_in, s_ready_insert}, '0);
        end
        pf = '0;
        if (m_busy && vin[g] && rdy) pf[g] = 1'b1;
        nb = m_busy; nd = 1'b0; nptr = m_ptr; ngid = m_gid;
        if (!m_busy) begin
            req = en & vin & hv;
            p = pick(m_ptr, req);
            if (p >= 0) begin
                nb = 1'b1;
                ngid = p;
                if (rec) gq.push_back(p);
            end
        end else if (rel) begin
            nb = 1'b0;
            nd = 1'b1;
            nptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_done = nd; m_ptr = nptr; m_gid = ngid;
        for (int i = 0; i < N; i++) begin
            if (pf[i]) begin
                if (beat[i] == len[i] - 1) begin
                    has[i] = 1'b0;
                    hv[i]  = 1'b0;
                end else begin
                    beat[i]++;
                    cdata[i] = $urandom;
                    ckeep[i] = (beat[i] == len[i] - 1) ? lkeep[i] : 4'hF;
                end
            end
        end
        drive();
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_gid = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) has[i] = 1'b0;
        hv = '0; vin = '0; en = '0; rdy = 1'b0; pf = '0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < N; i++) begin
            cdata[i] = '0; hdata[i] = '0; ckeep[i] = '0; hkeep[i] = '0;
            lkeep[i] = '0; hcnt[i] = '0; len[i] = 0; beat[i] = 0;
        end
        model_reset();
        pv = 100; ph = 100; pr = 100; flen = 3;
        en_mask = 4'b0001; rand_en = 1'b0; rec = 1'b0;

        vin = '1; hv = '1; en = '1; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {grant_valid, grant_id, pkt_done, core_valid_in,
                      core_valid_insert, s_ready_in, s_ready_insert}, '0);
        model_reset();
        rst_n = 1'b1;
        drive();

        repeat (30) step();

        flen = 0; en_mask = 4'b1111; rec = 1'b1;
        repeat (40) step();
        rec = 1'b0;
        chk("rr_count", 64'(gq.size() >= 8), 64'd1);
        for (int k = 0; k < 7 && k + 1 < gq.size(); k++)
            chk("rr_order", 64'(gq[k+1]), 64'((gq[k] + 1) % N));

        pv = 70; ph = 30; pr = 60; rand_en = 1'b1;
        repeat (2000) step();

        rand_en = 1'b0; en_mask = 4'b0100; pv = 100; ph = 100; pr = 50;
        w = 0;
        while (!(m_busy && m_gid == 2) && w < 60) begin
            step();
            w++;
        end
        chk("busy_ch2", 64'(m_busy && m_gid == 2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {grant_valid, grant_id, pkt_done, core_valid_in,
                          core_valid_insert, s_ready_in, s_ready_insert}, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en_mask = 4'b0101; pr = 100;
        drive();
        step();
        chk("rst_rr_gid", {grant_valid, grant_id}, {1'b1, 2'd0});
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
